// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator.
//   ACC_W_DEFAULT      default phase accumulator width
//   lock_state_t       lock state machine encoding
//   incr_for()         phase increment for a target output rate
//   INCR_3M375_AT_50M  increment for 3.375 MHz from a 50 MHz refclk
package clk_gen_pkg;

    localparam int unsigned ACC_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        LOCK_RESET    = 2'd0,
        LOCK_SETTLING = 2'd1,
        LOCK_LOCKED   = 2'd2
    } lock_state_t;

    // round(f_out * 2^ACC_W / f_ref), evaluated in integer arithmetic
    function automatic logic [ACC_W_DEFAULT-1:0] incr_for(
        input longint unsigned f_ref_hz,
        input longint unsigned f_out_hz
    );
        longint unsigned num;
        num = (f_out_hz << ACC_W_DEFAULT) + (f_ref_hz >> 1);
        return ACC_W_DEFAULT'(num / f_ref_hz);
    endfunction

    localparam logic [ACC_W_DEFAULT-1:0] INCR_3M375_AT_50M = 32'd289910292;

endpackage

// File: rtl/clk_gen_phase_acc.sv
// One DDS channel: increment/enable registers, phase accumulator and the
// registered enable-strobe and square-wave outputs.
//   refclk      clock
//   rst_n       synchronous active-low reset
//   wr          write strobe, already decoded for this channel
//   wr_incr     increment latched on wr
//   wr_en       run enable latched on wr
//   phase_sync  clears the accumulator
//   ce          one-cycle pulse per accumulator wrap
//   clk_sq      accumulator MSB
module clk_gen_phase_acc #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_incr,
    input  logic             wr_en,
    input  logic             phase_sync,
    output logic             ce,
    output logic             clk_sq
);

    logic [ACC_W-1:0] incr;
    logic [ACC_W-1:0] acc;
    logic             en;
    logic [ACC_W:0]   sum;

    // carry out of the accumulate is bit ACC_W of the widened sum
    always_comb begin
        sum = {1'b0, acc} + {1'b0, incr};
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            incr   <= '0;
            en     <= 1'b0;
            acc    <= '0;
            ce     <= 1'b0;
            clk_sq <= 1'b0;
        end else begin
            // written values are used from the next accumulate onward;
            // the accumulator itself is left alone so the phase is continuous
            if (wr) begin
                incr <= wr_incr;
                en   <= wr_en;
            end
            if (phase_sync) begin
                acc    <= '0;
                ce     <= 1'b0;
                clk_sq <= 1'b0;
            end else if (en) begin
                acc    <= sum[ACC_W-1:0];
                ce     <= sum[ACC_W];
                clk_sq <= sum[ACC_W-1];
            end else begin
                ce <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Run-time programmable multi-channel clock-enable generator.
//   refclk      sole clock
//   rst_n       synchronous active-low reset
//   cfg_we      configuration write strobe
//   cfg_ch      channel index for the write (out-of-range writes ignored)
//   cfg_incr    phase increment for that channel
//   cfg_en      channel run enable
//   phase_sync  clears all accumulators together
//   ce_out      per-channel one-cycle enable pulse per wrap
//   clk_out     per-channel accumulator MSB
//   locked      high once outputs run at the programmed rates
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned ACC_W       = ACC_W_DEFAULT,
    parameter  int unsigned LOCK_CYCLES = 1024,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_incr,
    input  logic              cfg_en,
    input  logic              phase_sync,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int unsigned        CNT_W     = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(LOCK_CYCLES);
    localparam logic [CH_W:0]      CH_LIMIT  = (CH_W + 1)'(NUM_CH);

    logic              cfg_valid;
    lock_state_t       state;
    lock_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    always_comb begin
        cfg_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gen_phase_acc #(
            .ACC_W(ACC_W)
        ) u_acc (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .wr         (cfg_valid && (cfg_ch == CH_W'(i))),
            .wr_incr    (cfg_incr),
            .wr_en      (cfg_en),
            .phase_sync (phase_sync),
            .ce         (ce_out[i]),
            .clk_sq     (clk_out[i])
        );
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state <= LOCK_RESET;
            cnt   <= LOCK_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first cycle out of reset counts like a settling cycle, so a write
    // and a reset release both leave locked low for LOCK_CYCLES+1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (cfg_valid) begin
            state_nxt = LOCK_SETTLING;
            cnt_nxt   = LOCK_LOAD;
        end else begin
            case (state)
                LOCK_RESET: begin
                    state_nxt = LOCK_SETTLING;
                    cnt_nxt   = cnt - 1'b1;
                end
                LOCK_SETTLING: begin
                    if (cnt == '0) begin
                        state_nxt = LOCK_LOCKED;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                LOCK_LOCKED: begin
                    state_nxt = LOCK_LOCKED;
                end
                default: begin
                    state_nxt = LOCK_RESET;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCK_LOCKED);
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised, run-time programmable successor to the fixed four-output PLL wrapper.
- Generates NUM_CH independent clock-enable strobes and square-wave reference outputs from a single fabric clock, using per-channel phase accumulators (DDS).
- Covers low-rate emulator clocks (3.375 MHz CPU, video/sound dividers) without consuming extra PLL outputs.
- Rates are reprogrammable at run time; a PLL-style locked flag reports settled operation.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- ACC_W, 32, phase accumulator width in bits; output frequency = f_refclk * incr / 2^ACC_W.
- LOCK_CYCLES, 1024, refclk cycles after reset or reconfiguration before locked asserts (>=1).

Ports:
- refclk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  one-cycle write strobe for the channel configuration.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write.
- cfg_incr  in  ACC_W  phase increment for that channel.
- cfg_en  in  1  channel run enable written with cfg_incr.
- phase_sync  in  1  one-cycle strobe; clears all accumulators together.
- ce_out  out  NUM_CH  one-cycle enable pulse per accumulator wrap.
- clk_out  out  NUM_CH  accumulator MSB per channel (approx. square wave, fabric use only).
- locked  out  1  high once outputs are stable at the programmed rates.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All accumulators, increments and enables cleared.
  - ce_out=0, clk_out=0, locked=0.
  - Lock counter loaded with LOCK_CYCLES.
- Per channel, each cycle when enabled:
  - {carry, acc} <= acc + incr, performed at ACC_W+1 bits.
  - ce_out[i] <= carry, registered, so exactly one cycle high per wrap.
  - clk_out[i] <= MSB of the new acc.
- Disabled channel: acc holds its value, ce_out[i]=0, clk_out[i] holds.
- Configuration write:
  - When cfg_we=1, the channel at cfg_ch latches cfg_incr and cfg_en.
  - The new increment is first used in the accumulate of the following cycle, i.e. one cycle of latency.
  - The accumulator is not cleared, so there is no phase jump.
  - cfg_ch >= NUM_CH: write ignored, locked unaffected.
- incr boundaries:
  - incr=0: ce_out never pulses.
  - incr=2^(ACC_W-1): ce_out pulses every 2nd cycle.
  - Maximum rate is refclk/2 for a clean pulse train.
  - incr > 2^(ACC_W-1) is legal; it aliases and produces an irregular pattern.
- phase_sync: all accumulators load 0 that cycle; ce_out is 0 that cycle. Increment/enable writes in the same cycle still take effect.
- Simultaneous cfg_we and phase_sync on the same channel: the accumulator clears and the new incr applies from the next cycle.
- Lock state machine, states RESET -> SETTLING -> LOCKED:
  - SETTLING: counter decrements each cycle; locked=0. At count 0 go to LOCKED; locked=1 from the next cycle.
  - LOCKED: any valid cfg_we reloads the counter and returns to SETTLING. locked drops the cycle after the write.
  - A write during SETTLING reloads the counter; no extra state.
  - phase_sync does not affect lock.
  - Reset mid-operation returns to SETTLING with all state cleared.
- Total latency write -> first affected ce_out: 2 cycles.

Decomposition:
- Package clk_gen_pkg:
  - ACC_W default constant.
  - Lock state enum (RESET, SETTLING, LOCKED).
  - Constant function incr_for(f_ref_hz, f_out_hz) returning round(f_out*2^ACC_W/f_ref).
  - Precomputed INCR_3M375_AT_50M = 289910292.
- Sub-module clk_gen_phase_acc: one channel, holding the incr/en registers, accumulator, carry and ce/clk registers. Instantiated NUM_CH times by generate.
- The lock counter/FSM lives in the top.

Test Plan:
- Reset hold 5 cycles then release, no writes -> ce_out=0, clk_out=0; locked rises exactly LOCK_CYCLES+1 cycles after release.
- Write ch0 incr=2^31 en=1 (ACC_W=32) -> ce_out[0] pulses every 2nd cycle starting 2 cycles after the write; locked drops next cycle, reasserts after LOCK_CYCLES.
- Ch1 incr=2^30, ch2 incr=0x33333333, ch3 incr=289910292, over 100000 cycles -> pulse counts 25000, 20000 and 6750 (±1); ch2 period pattern 5 cycles.
- Reprogram ch1 from 2^30 to 2^29 mid-run -> next interval measured from the unchanged accumulator (no phase jump), then steady 8-cycle period; other channels unaffected.
- Channels running, then phase_sync together with cfg_we to ch0 -> all ce_out low that cycle; channels with equal incr pulse on identical cycles afterwards.
- Write cfg_ch=NUM_CH (NUM_CH=3 build) while LOCKED -> no channel changes, locked stays 1; then reset mid-run -> outputs 0 on the next cycle.
